mole_round_controller: RTL and testbench

//   Game sequencer for whack-a-mole. On a play start it runs ROUNDS mole rounds: hole down for

---
 rtl/mole_round_controller_pkg.sv | 28 ++
 rtl/mole_round_controller_timer.sv | 38 +++
 rtl/mole_round_controller.sv | 182 ++++++++++++++++++
 tb/tb_mole_round_controller.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_round_controller_pkg.sv
// Shared definitions for the whack-a-mole round sequencer: FSM states,
// score/image constants and the hole-picking rule.
package mole_round_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DOWN      = 3'd1,
        ST_PICK      = 3'd2,
        ST_UP        = 3'd3,
        ST_ROUND_END = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    localparam logic [7:0] SCORE_MAX = 8'd255;
    localparam logic [3:0] NO_MOLE   = 4'b0000;

    // Never show the same hole twice in a row: step to the next hole
    // (3 wraps to 0) when the random pick repeats the previous one.
    function automatic logic [1:0] pick_hole(input logic [1:0] raw, input logic [1:0] prev);
        logic [1:0] idx;
        idx = raw;
        if (raw == prev) begin
            idx = raw + 2'd1;
        end
        return idx;
    endfunction

endpackage

// File: rtl/mole_round_controller_timer.sv
// Phase timer for the mole sequencer: loadable down-counter that stops at
// zero. done_o is high whenever the count has reached zero.
module mole_phase_timer #(
    parameter int TMR_W = 25
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Load has priority; decrement is ignored once the count is zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mole_round_controller.sv
// Whack-a-mole game sequencer: runs ROUNDS rounds of down time, hole pick,
// mole up until hit or timeout, then scoring. All outputs are registered.
module mole_round_controller
    import mole_round_controller_pkg::*;
#(
    parameter int NUM_HOLES   = 4,
    parameter int UP_CYCLES   = 25000000,
    parameter int DOWN_CYCLES = 12500000,
    parameter int ROUNDS      = 16,
    parameter int TMR_W       = 25
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 play,
    input  logic [3:0]           rand_num,
    input  logic [NUM_HOLES-1:0] keys,
    output logic                 mole_up,
    output logic [NUM_HOLES-1:0] mole_sel,
    output logic                 hit,
    output logic                 miss,
    output logic [7:0]           score,
    output logic [7:0]           rounds_left,
    output logic                 game_over
);

    localparam logic [TMR_W-1:0] DOWN_LOAD  = TMR_W'(DOWN_CYCLES - 1);
    localparam logic [TMR_W-1:0] UP_LOAD    = TMR_W'(UP_CYCLES - 1);
    localparam logic [7:0]       ROUND_LOAD = 8'(ROUNDS);

    state_e                 state_q, state_d;
    logic                   play_q;
    logic [NUM_HOLES-1:0]   keys_q;
    logic [1:0]             prev_idx_q, prev_idx_d;
    logic                   mole_up_q, mole_up_d;
    logic [NUM_HOLES-1:0]   mole_sel_q, mole_sel_d;
    logic                   hit_q, hit_d;
    logic                   miss_q, miss_d;
    logic [7:0]             score_q, score_d;
    logic [7:0]             rounds_q, rounds_d;
    logic                   game_over_q, game_over_d;

    logic                   play_rise;
    logic [NUM_HOLES-1:0]   key_rise;
    logic                   tmr_load;
    logic [TMR_W-1:0]       tmr_val;
    logic                   tmr_dec;
    logic                   tmr_done;
    logic [1:0]             unusedRandBits;

    assign play_rise      = play & ~play_q;
    assign key_rise       = keys & ~keys_q;
    assign unusedRandBits = rand_num[3:2];

    mole_phase_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .clock      (clock),
        .resetn     (resetn),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .done_o     (tmr_done)
    );

    // Next-state, timer control and registered-output values for the game FSM.
    always_comb begin
        state_d    = state_q;
        prev_idx_d = prev_idx_q;
        mole_sel_d = mole_sel_q;
        score_d    = score_q;
        rounds_d   = rounds_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = DOWN_LOAD;
        tmr_dec    = 1'b0;

        if ((state_q != ST_IDLE) && !play) begin
            state_d    = ST_IDLE;
            mole_sel_d = NO_MOLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (play_rise) begin
                        state_d  = ST_DOWN;
                        score_d  = 8'd0;
                        rounds_d = ROUND_LOAD;
                        tmr_load = 1'b1;
                        tmr_val  = DOWN_LOAD;
                    end
                end
                ST_DOWN: begin
                    if (tmr_done) begin
                        state_d = ST_PICK;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_PICK: begin
                    prev_idx_d = pick_hole(rand_num[1:0], prev_idx_q);
                    mole_sel_d = NUM_HOLES'(1) << prev_idx_d;
                    tmr_load   = 1'b1;
                    tmr_val    = UP_LOAD;
                    state_d    = ST_UP;
                end
                ST_UP: begin
                    if (key_rise[prev_idx_q]) begin
                        hit_d      = 1'b1;
                        mole_sel_d = NO_MOLE;
                        state_d    = ST_ROUND_END;
                        if (score_q != SCORE_MAX) begin
                            score_d = score_q + 8'd1;
                        end
                    end else if (tmr_done) begin
                        miss_d     = 1'b1;
                        mole_sel_d = NO_MOLE;
                        state_d    = ST_ROUND_END;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ST_ROUND_END: begin
                    rounds_d = rounds_q - 8'd1;
                    if (rounds_d == 8'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_DOWN;
                        tmr_load = 1'b1;
                        tmr_val  = DOWN_LOAD;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        mole_up_d   = (state_d == ST_UP);
        game_over_d = (state_d == ST_DONE);
    end

    // State, edge-detect history, counters and registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            play_q      <= 1'b0;
            keys_q      <= '0;
            prev_idx_q  <= 2'd0;
            mole_up_q   <= 1'b0;
            mole_sel_q  <= '0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            score_q     <= 8'd0;
            rounds_q    <= 8'd0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            play_q      <= play;
            keys_q      <= keys;
            prev_idx_q  <= prev_idx_d;
            mole_up_q   <= mole_up_d;
            mole_sel_q  <= mole_sel_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            score_q     <= score_d;
            rounds_q    <= rounds_d;
            game_over_q <= game_over_d;
        end
    end

    assign mole_up     = mole_up_q;
    assign mole_sel    = mole_sel_q;
    assign hit         = hit_q;
    assign miss        = miss_q;
    assign score       = score_q;
    assign rounds_left = rounds_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_mole_round_controller.sv
// Self-checking bench for mole_round_controller with short phase lengths.
// A directed vector table covers the first round, hand-written sequences
// cover the corner cases, and a random run is checked against a
// behavioural game model.
module tb_mole_round_controller;

    localparam int UP_C   = 8;
    localparam int DOWN_C = 4;
    localparam int NROUND = 3;

    localparam int P_IDLE = 0;
    localparam int P_DOWN = 1;
    localparam int P_PICK = 2;
    localparam int P_UP   = 3;
    localparam int P_END  = 4;
    localparam int P_DONE = 5;

    logic       clock = 1'b0;
    logic       resetn;
    logic       play;
    logic [3:0] randNum;
    logic [3:0] keys;
    logic       moleUp;
    logic [3:0] moleSel;
    logic       hit;
    logic       miss;
    logic [7:0] score;
    logic [7:0] roundsLeft;
    logic       gameOver;

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model state
    int       mPhase;
    int       mElapsed;
    int       mHole;
    int       mScore;
    int       mRounds;
    logic     mHit;
    logic     mMiss;
    logic     mPrevPlay;
    logic [3:0] mPrevKeys;

    typedef struct {
        logic        inPlay;
        logic [3:0]  inRand;
        logic [3:0]  inKeys;
        logic [23:0] expOut;
    } vector_t;

    vector_t table_q[$];

    always #5 clock = ~clock;

    mole_round_controller #(
        .NUM_HOLES   (4),
        .UP_CYCLES   (UP_C),
        .DOWN_CYCLES (DOWN_C),
        .ROUNDS      (NROUND),
        .TMR_W       (4)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .play        (play),
        .rand_num    (randNum),
        .keys        (keys),
        .mole_up     (moleUp),
        .mole_sel    (moleSel),
        .hit         (hit),
        .miss        (miss),
        .score       (score),
        .rounds_left (roundsLeft),
        .game_over   (gameOver)
    );

    function automatic logic [23:0] packOut(input logic up, input logic [3:0] sel, input logic h,
                                            input logic m, input int sc, input int rl, input logic go);
        return {up, sel, h, m, 8'(sc), 8'(rl), go};
    endfunction

    function automatic logic [23:0] dutOut();
        return {moleUp, moleSel, hit, miss, score, roundsLeft, gameOver};
    endfunction

    function automatic logic [23:0] modelOut();
        logic [3:0] sel;
        sel = (mPhase == P_UP) ? 4'(1 << mHole) : 4'b0000;
        return packOut(mPhase == P_UP, sel, mHit, mMiss, mScore, mRounds, mPhase == P_DONE);
    endfunction

    function automatic vector_t mkRow(input logic p, input logic [3:0] r, input logic [3:0] k,
                                      input logic [23:0] e);
        vector_t v;
        v.inPlay = p;
        v.inRand = r;
        v.inKeys = k;
        v.expOut = e;
        return v;
    endfunction

    task automatic modelReset();
        mPhase    = P_IDLE;
        mElapsed  = 0;
        mHole     = 0;
        mScore    = 0;
        mRounds   = 0;
        mHit      = 1'b0;
        mMiss     = 1'b0;
        mPrevPlay = 1'b0;
        mPrevKeys = 4'b0000;
    endtask

    // Game rules applied once per clock edge, using the inputs seen at that edge.
    task automatic modelStep();
        logic       playRise;
        logic [3:0] keyRise;
        int         pick;
        playRise = play && !mPrevPlay;
        keyRise  = keys & ~mPrevKeys;
        mHit  = 1'b0;
        mMiss = 1'b0;
        if (mPhase != P_IDLE && !play) begin
            mPhase = P_IDLE;
        end else begin
            case (mPhase)
                P_IDLE: if (playRise) begin
                    mPhase = P_DOWN; mElapsed = 0; mScore = 0; mRounds = NROUND;
                end
                P_DOWN: begin
                    mElapsed++;
                    if (mElapsed == DOWN_C) mPhase = P_PICK;
                end
                P_PICK: begin
                    pick = int'(randNum) % 4;
                    if (pick == mHole) pick = (pick + 1) % 4;
                    mHole = pick; mPhase = P_UP; mElapsed = 0;
                end
                P_UP: begin
                    mElapsed++;
                    if (keyRise[mHole]) begin
                        mHit = 1'b1; mPhase = P_END;
                        if (mScore < 255) mScore++;
                    end else if (mElapsed == UP_C) begin
                        mMiss = 1'b1; mPhase = P_END;
                    end
                end
                P_END: begin
                    mRounds--;
                    mElapsed = 0;
                    mPhase = (mRounds == 0) ? P_DONE : P_DOWN;
                end
                default: ;
            endcase
        end
        mPrevPlay = play;
        mPrevKeys = keys;
    endtask

    task automatic applyStimulus(input logic p, input logic [3:0] r, input logic [3:0] k);
        play    = p;
        randNum = r;
        keys    = k;
    endtask

    task automatic checkOutput(input string name, input logic [23:0] expected);
        vectors++;
        if (dutOut() !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (up,sel,hit,miss,score,rounds,over)",
                     name, dutOut(), expected);
        end
    endtask

    task automatic checkField(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        modelStep();
        #1;
    endtask

    task automatic stepCheck(input string name);
        tick();
        checkOutput(name, modelOut());
    endtask

    task automatic stepN(input int n);
        for (int i = 0; i < n; i++) stepCheck("seq");
    endtask

    task automatic waitPhase(input int target, input int budget);
        int n = 0;
        while (mPhase != target && n < budget) begin
            stepCheck("wait");
            n++;
        end
        if (mPhase != target) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL waitPhase: phase %0d expected %0d", mPhase, target);
        end
    endtask

    initial begin
        resetn = 1'b0;
        applyStimulus(1'b0, 4'd0, 4'd0);
        modelReset();

        // First game round: 4 DOWN + 1 PICK cycles, 8 UP cycles, miss, round count drops
        table_q.push_back(mkRow(1'b1, 4'd0, 4'd0, packOut(0, 4'b0000, 0, 0, 0, 3, 0)));
        for (int i = 0; i < 4; i++)
            table_q.push_back(mkRow(1'b1, 4'd0, 4'd0, packOut(0, 4'b0000, 0, 0, 0, 3, 0)));
        for (int i = 0; i < UP_C; i++)
            table_q.push_back(mkRow(1'b1, 4'd0, 4'd0, packOut(1, 4'b0010, 0, 0, 0, 3, 0)));
        table_q.push_back(mkRow(1'b1, 4'd0, 4'd0, packOut(0, 4'b0000, 0, 1, 0, 3, 0)));
        table_q.push_back(mkRow(1'b1, 4'd0, 4'd0, packOut(0, 4'b0000, 0, 0, 0, 2, 0)));

        #12;
        checkOutput("reset", 24'h0);
        resetn = 1'b1;

        for (int i = 0; i < table_q.size(); i++) begin
            applyStimulus(table_q[i].inPlay, table_q[i].inRand, table_q[i].inKeys);
            tick();
            checkOutput($sformatf("table%0d", i), table_q[i].expOut);
        end

        // Round 2: hole 2 picked, correct key rises on the 3rd UP cycle
        waitPhase(P_PICK, 20);
        randNum = 4'b0110;
        stepCheck("pick2");
        checkField("sel_hole2", int'(moleSel), 4);
        stepN(1);
        keys = 4'b0100;
        stepCheck("hit2");
        checkField("hit2_pulse", int'(hit), 1);
        checkField("hit2_score", int'(score), 1);
        checkField("hit2_moleup", int'(moleUp), 0);
        keys = 4'b0000;

        // Round 3: wrong key edge is ignored, mole times out
        waitPhase(P_PICK, 20);
        randNum = 4'b0000;
        stepCheck("pick3");
        keys = 4'b1000;
        waitPhase(P_END, 20);
        checkField("wrongkey_miss", int'(miss), 1);
        stepCheck("done");
        checkField("done_over", int'(gameOver), 1);
        checkField("done_rounds", int'(roundsLeft), 0);
        stepN(3);
        checkField("done_score_held", int'(score), 1);
        keys = 4'b0000;

        // Leave DONE, then restart clears the score
        play = 1'b0;
        stepCheck("idle");
        checkField("idle_over", int'(gameOver), 0);
        checkField("idle_score_held", int'(score), 1);
        play = 1'b1;
        stepCheck("restart");
        checkField("restart_score", int'(score), 0);
        checkField("restart_rounds", int'(roundsLeft), 3);

        // Repeat pick of hole 3 wraps to hole 0; key edge on the final UP cycle
        waitPhase(P_PICK, 20);
        randNum = 4'b0011;
        stepCheck("pickw1");
        checkField("sel_hole3", int'(moleSel), 8);
        waitPhase(P_END, 20);
        waitPhase(P_PICK, 20);
        randNum = 4'b1111;
        stepCheck("pickw2");
        checkField("sel_wrap", int'(moleSel), 1);
        stepN(UP_C - 1);
        keys = 4'b0001;
        stepCheck("lasthit");
        checkField("last_hit", int'(hit), 1);
        checkField("last_nomiss", int'(miss), 0);
        keys = 4'b0000;

        // Key held since DOWN produces no edge, so the round is a miss
        waitPhase(P_DOWN, 5);
        keys = 4'b0010;
        waitPhase(P_PICK, 20);
        randNum = 4'b0001;
        stepCheck("pickheld");
        waitPhase(P_END, 20);
        checkField("held_miss", int'(miss), 1);
        checkField("held_nohit", int'(hit), 0);
        keys = 4'b0000;
        waitPhase(P_DONE, 5);

        // Abort mid-UP after scoring one hit
        play = 1'b0;
        stepCheck("abort_idle");
        play = 1'b1;
        waitPhase(P_PICK, 20);
        randNum = 4'($urandom);
        stepCheck("pickab");
        keys = 4'(1 << mHole);
        stepCheck("abhit");
        keys = 4'b0000;
        waitPhase(P_PICK, 20);
        stepN(2);
        play = 1'b0;
        stepCheck("abort");
        checkField("abort_moleup", int'(moleUp), 0);
        checkField("abort_sel", int'(moleSel), 0);
        checkField("abort_score", int'(score), 1);

        // Async reset mid-DOWN clears outputs immediately
        play = 1'b1;
        stepN(3);
        resetn = 1'b0;
        #1;
        checkOutput("async_reset", 24'h0);
        modelReset();
        #2;
        resetn = 1'b1;

        // Randomised play checked against the model
        for (int n = 0; n < 1500; n++) begin
            stepCheck("random");
            randNum = 4'($urandom);
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 7) == 0) keys[b] = ~keys[b];
            if (!play) begin
                if ($urandom_range(0, 1) == 0) play = 1'b1;
            end else if (mPhase == P_DONE) begin
                if ($urandom_range(0, 3) == 0) play = 1'b0;
            end else if ($urandom_range(0, 99) == 0) begin
                play = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
